// File: rtl/imuldiv_int_mul_pipelined_param_if.sv
// Request/response bundle for the pipelined multiplier.
// Handshake: a transfer happens on any cycle where val && rdy are both high on the
// same interface (mulreq_* or mulresp_*); the sender holds msg stable while val && !rdy.
interface imuldiv_int_mul_pipelined_param_if #(
  parameter int W = 32
);
  logic [W-1:0]   mulreq_msg_a;
  logic [W-1:0]   mulreq_msg_b;
  logic [1:0]     mulreq_msg_fn;
  logic           mulreq_val;
  logic           mulreq_rdy;
  logic [2*W-1:0] mulresp_msg_result;
  logic           mulresp_val;
  logic           mulresp_rdy;

  // Requester / response consumer side
  modport master (
    output mulreq_msg_a, mulreq_msg_b, mulreq_msg_fn, mulreq_val,
    input  mulreq_rdy,
    input  mulresp_msg_result, mulresp_val,
    output mulresp_rdy
  );

  // Multiplier side
  modport slave (
    input  mulreq_msg_a, mulreq_msg_b, mulreq_msg_fn, mulreq_val,
    output mulreq_rdy,
    output mulresp_msg_result, mulresp_val,
    input  mulresp_rdy
  );
endinterface

// File: rtl/imuldiv_int_mul_pipelined_param.sv
// Pipelined integer multiplier for the imuldiv unit.
// Stage 0 latches operand magnitudes and the result sign; stage k adds the partial
// product of |A| with slice k of |B|. The last stage negates when the sign is set.
// The whole pipe advances together and holds in place under response backpressure.
// Optional build macro: IMULDIV_MUL_SKID_EN adds a 2-entry output skid FIFO so the
// request ready no longer depends combinationally on response ready (except when full).
module imuldiv_int_mul_pipelined_param #(
  parameter int W         = 32,
  parameter int NUM_STAGE = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  imuldiv_int_mul_pipelined_param_if.slave        mul_if
);

  localparam int S = W / NUM_STAGE;
  localparam int L = NUM_STAGE - 1;

  // Reject configurations where the multiplier cannot be sliced evenly
  if ((NUM_STAGE < 1) || (NUM_STAGE > W) || ((W % NUM_STAGE) != 0)) begin : g_bad_cfg
    $error("imuldiv_int_mul_pipelined_param: NUM_STAGE must be 1..W and divide W");
  end

  // Partial product of |A| with one S-bit slice of |B|, aligned to slice position k
  function automatic logic [2*W-1:0] part_prod(input logic [W-1:0] a,
                                               input logic [S-1:0] bs,
                                               input int k);
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    a_ext = {{W{1'b0}}, a};
    b_ext = {{(2*W-S){1'b0}}, bs};
    return (a_ext * b_ext) << (k * S);
  endfunction

  // Stage registers
  logic [NUM_STAGE-1:0] val_q;
  logic [NUM_STAGE-1:0] sign_q;
  logic [W-1:0]         a_q   [NUM_STAGE];
  logic [W-1:0]         b_q   [NUM_STAGE];
  logic [2*W-1:0]       acc_q [NUM_STAGE];
  logic [2*W-1:0]       acc_d [NUM_STAGE];

  logic           adv;
  logic           req_a_neg;
  logic           req_b_neg;
  logic [W-1:0]   req_abs_a;
  logic [W-1:0]   req_abs_b;
  logic           req_sign;
  logic [2*W-1:0] last_result;

  // Operand decode: A signed for fn 0/2, B signed for fn 0; fn 3 falls through as unsigned
  always_comb begin
    req_a_neg = 1'b0;
    req_b_neg = 1'b0;
    if ((mul_if.mulreq_msg_fn == 2'd0) || (mul_if.mulreq_msg_fn == 2'd2)) begin
      req_a_neg = mul_if.mulreq_msg_a[W-1];
    end
    if (mul_if.mulreq_msg_fn == 2'd0) begin
      req_b_neg = mul_if.mulreq_msg_b[W-1];
    end
    // The most negative value negates to itself, which is its exact unsigned magnitude
    req_abs_a = req_a_neg ? -mul_if.mulreq_msg_a : mul_if.mulreq_msg_a;
    req_abs_b = req_b_neg ? -mul_if.mulreq_msg_b : mul_if.mulreq_msg_b;
    req_sign  = req_a_neg ^ req_b_neg;
  end

  // Next accumulator value entering each stage
  always_comb begin
    for (int k = 0; k < NUM_STAGE; k++) begin
      acc_d[k] = '0;
    end
    acc_d[0] = part_prod(req_abs_a, req_abs_b[S-1:0], 0);
    for (int k = 1; k < NUM_STAGE; k++) begin
      acc_d[k] = acc_q[k-1] + part_prod(a_q[k-1], b_q[k-1][k*S +: S], k);
    end
  end

  // Stage shift register: everything moves together on adv, otherwise holds
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q  <= '0;
      sign_q <= '0;
      for (int k = 0; k < NUM_STAGE; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        acc_q[k] <= '0;
      end
    end else if (adv) begin
      // adv is also mulreq_rdy, so val alone marks a request transfer here
      val_q[0]  <= mul_if.mulreq_val;
      sign_q[0] <= req_sign;
      a_q[0]    <= req_abs_a;
      b_q[0]    <= req_abs_b;
      acc_q[0]  <= acc_d[0];
      for (int k = 1; k < NUM_STAGE; k++) begin
        val_q[k]  <= val_q[k-1];
        sign_q[k] <= sign_q[k-1];
        a_q[k]    <= a_q[k-1];
        b_q[k]    <= b_q[k-1];
        acc_q[k]  <= acc_d[k];
      end
    end
  end

  // Apply the result sign to the finished magnitude
  always_comb begin
    last_result = sign_q[L] ? -acc_q[L] : acc_q[L];
  end

`ifdef IMULDIV_MUL_SKID_EN
  logic [2*W-1:0] fifo_q [2];
  logic [1:0]     fifo_cnt_q;
  logic           fifo_wr_q;
  logic           fifo_rd_q;
  logic           fifo_push;
  logic           fifo_pop;

  // Advance from FIFO occupancy; response ready only matters once both entries are full
  always_comb begin
    adv       = (fifo_cnt_q < 2'd2) || ((fifo_cnt_q == 2'd2) && mul_if.mulresp_rdy);
    fifo_push = val_q[L] && adv;
    fifo_pop  = (fifo_cnt_q != 2'd0) && mul_if.mulresp_rdy;
    mul_if.mulreq_rdy         = adv;
    mul_if.mulresp_val        = (fifo_cnt_q != 2'd0);
    mul_if.mulresp_msg_result = fifo_q[fifo_rd_q];
  end

  // Skid FIFO pointers, occupancy and storage
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_cnt_q <= '0;
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      if (fifo_push) begin
        fifo_q[fifo_wr_q] <= last_result;
        fifo_wr_q         <= ~fifo_wr_q;
      end
      if (fifo_pop) begin
        fifo_rd_q <= ~fifo_rd_q;
      end
      if (fifo_push && !fifo_pop) begin
        fifo_cnt_q <= fifo_cnt_q + 2'd1;
      end else if (!fifo_push && fifo_pop) begin
        fifo_cnt_q <= fifo_cnt_q - 2'd1;
      end
    end
  end
`else
  // Advance whenever the last stage is empty or its result is being taken
  always_comb begin
    adv = !val_q[L] || mul_if.mulresp_rdy;
    mul_if.mulreq_rdy         = adv;
    mul_if.mulresp_val        = val_q[L];
    mul_if.mulresp_msg_result = last_result;
  end
`endif

endmodule

// File: tb/tb_imuldiv_int_mul_pipelined_param.sv
// Directed bench for imuldiv_int_mul_pipelined_param (W=32, NUM_STAGE=4).
module tb_imuldiv_int_mul_pipelined_param;

  localparam int W         = 32;
  localparam int NUM_STAGE = 4;
`ifdef IMULDIV_MUL_SKID_EN
  localparam int LAT = NUM_STAGE + 1;
`else
  localparam int LAT = NUM_STAGE;
`endif
  localparam int NV = 15;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [W-1:0]   va [NV];
  logic [W-1:0]   vb [NV];
  logic [1:0]     vf [NV];
  logic [2*W-1:0] ve [NV];
  logic [2*W-1:0] exp_q [$];

  imuldiv_int_mul_pipelined_param_if #(.W(W)) mul_if ();

  imuldiv_int_mul_pipelined_param #(.W(W), .NUM_STAGE(NUM_STAGE)) dut (
    .clk    (clk),
    .reset  (reset),
    .mul_if (mul_if.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic v);
    mul_if.mulreq_msg_a  = va[i];
    mul_if.mulreq_msg_b  = vb[i];
    mul_if.mulreq_msg_fn = vf[i];
    mul_if.mulreq_val    = v;
  endtask

  // One isolated operation: measure cycles to response and check the product
  task automatic do_single(input int i);
    int n;
    mul_if.mulresp_rdy = 1'b1;
    drive_req(i, 1'b1);
    #1;
    check($sformatf("single%0d_req_rdy", i), {63'd0, mul_if.mulreq_rdy}, 64'd1);
    tick();
    mul_if.mulreq_val = 1'b0;
    n = 1;
    while ((mul_if.mulresp_val !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    check($sformatf("single%0d_latency", i), 64'(n), 64'(LAT));
    check($sformatf("single%0d_result", i), mul_if.mulresp_msg_result, ve[i]);
    tick();
  endtask

  // Back-to-back stream of cnt ops from vector first, with an optional response stall
  task automatic run_stream(input int first, input int cnt, input int stall_at, input int stall_len);
    int  sent;
    int  recv;
    int  c;
    logic stalled;
    sent = 0;
    recv = 0;
    c    = 0;
    while (((sent < cnt) || (recv < cnt)) && (c < 100)) begin
      if (sent < cnt) drive_req(first + sent, 1'b1);
      else            mul_if.mulreq_val = 1'b0;
      stalled = (c >= stall_at) && (c < stall_at + stall_len);
      mul_if.mulresp_rdy = !stalled;
      #1;
      if (stalled && mul_if.mulresp_val && (exp_q.size() > 0)) begin
        check($sformatf("stall_hold_c%0d", c), mul_if.mulresp_msg_result, exp_q[0]);
      end
      if ((stall_len > 0) && (c == stall_at + stall_len - 1)) begin
        check("stall_resp_val", {63'd0, mul_if.mulresp_val}, 64'd1);
        check("stall_req_rdy", {63'd0, mul_if.mulreq_rdy}, 64'd0);
      end
      if (mul_if.mulresp_val && mul_if.mulresp_rdy) begin
        check($sformatf("stream%0d_resp%0d", first, recv), mul_if.mulresp_msg_result, exp_q.pop_front());
        recv++;
      end
      if (mul_if.mulreq_val && mul_if.mulreq_rdy) begin
        exp_q.push_back(ve[first + sent]);
        sent++;
      end
      tick();
      c++;
    end
    mul_if.mulreq_val  = 1'b0;
    mul_if.mulresp_rdy = 1'b1;
    check($sformatf("stream%0d_timeout", first), {63'd0, (c < 100)}, 64'd1);
    check($sformatf("stream%0d_count", first), 64'(recv), 64'(cnt));
    check($sformatf("stream%0d_leftover", first), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // Directed vectors: fn, A, B, hand-computed 64-bit product
    vf[0]  = 2'd0; va[0]  = 32'h0000_0007; vb[0]  = 32'hFFFF_FFFD; ve[0]  = 64'hFFFF_FFFF_FFFF_FFEB;
    vf[1]  = 2'd1; va[1]  = 32'hFFFF_FFFF; vb[1]  = 32'hFFFF_FFFF; ve[1]  = 64'hFFFF_FFFE_0000_0001;
    vf[2]  = 2'd0; va[2]  = 32'hFFFF_FFFF; vb[2]  = 32'hFFFF_FFFF; ve[2]  = 64'h0000_0000_0000_0001;
    vf[3]  = 2'd2; va[3]  = 32'h8000_0000; vb[3]  = 32'hFFFF_FFFF; ve[3]  = 64'h8000_0000_8000_0000;
    vf[4]  = 2'd0; va[4]  = 32'h8000_0000; vb[4]  = 32'h8000_0000; ve[4]  = 64'h4000_0000_0000_0000;
    vf[5]  = 2'd3; va[5]  = 32'hFFFF_FFFF; vb[5]  = 32'h0000_0002; ve[5]  = 64'h0000_0001_FFFF_FFFE;
    vf[6]  = 2'd1; va[6]  = 32'h1234_5678; vb[6]  = 32'h0000_0010; ve[6]  = 64'h0000_0001_2345_6780;
    vf[7]  = 2'd0; va[7]  = 32'h0000_0000; vb[7]  = 32'h8000_0000; ve[7]  = 64'h0000_0000_0000_0000;
    vf[8]  = 2'd2; va[8]  = 32'hFFFF_FFFE; vb[8]  = 32'h0000_0003; ve[8]  = 64'hFFFF_FFFF_FFFF_FFFA;
    vf[9]  = 2'd0; va[9]  = 32'h0001_0000; vb[9]  = 32'hFFFF_0000; ve[9]  = 64'hFFFF_FFFF_0000_0000;
    vf[10] = 2'd1; va[10] = 32'h8000_0000; vb[10] = 32'h8000_0000; ve[10] = 64'h4000_0000_0000_0000;
    vf[11] = 2'd0; va[11] = 32'h7FFF_FFFF; vb[11] = 32'h7FFF_FFFF; ve[11] = 64'h3FFF_FFFF_0000_0001;
    vf[12] = 2'd2; va[12] = 32'h0000_0003; vb[12] = 32'h8000_0000; ve[12] = 64'h0000_0001_8000_0000;
    vf[13] = 2'd0; va[13] = 32'hFFFF_FFF9; vb[13] = 32'h0000_0006; ve[13] = 64'hFFFF_FFFF_FFFF_FFD6;
    vf[14] = 2'd2; va[14] = 32'hFFFF_FFFF; vb[14] = 32'h0000_0001; ve[14] = 64'hFFFF_FFFF_FFFF_FFFF;

    // Reset state
    reset              = 1'b1;
    mul_if.mulreq_val  = 1'b0;
    mul_if.mulreq_msg_a  = '0;
    mul_if.mulreq_msg_b  = '0;
    mul_if.mulreq_msg_fn = '0;
    mul_if.mulresp_rdy = 1'b1;
    repeat (2) tick();
    check("rst_resp_val", {63'd0, mul_if.mulresp_val}, 64'd0);
    check("rst_result", mul_if.mulresp_msg_result, 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_req_rdy", {63'd0, mul_if.mulreq_rdy}, 64'd1);

    // Isolated ops: latency and signed/unsigned/mixed corners
    for (int i = 0; i < 5; i++) do_single(i);

    // Full-rate stream with response ready held high
    run_stream(5, 8, 1000, 0);

    // Stream with a 5-cycle response stall once the pipe is full
    run_stream(0, 8, 4, 5);

    // Request ready must not move when response ready toggles on an empty pipe
    mul_if.mulresp_rdy = 1'b0;
    #1;
    check("toggle_rdy_lo", {63'd0, mul_if.mulreq_rdy}, 64'd1);
    mul_if.mulresp_rdy = 1'b1;
    #1;
    check("toggle_rdy_hi", {63'd0, mul_if.mulreq_rdy}, 64'd1);
    tick();

    // Reset with three ops in flight discards them
    for (int i = 0; i < 3; i++) begin
      drive_req(13 + (i % 2), 1'b1);
      tick();
    end
    mul_if.mulreq_val = 1'b0;
    reset = 1'b1;
    tick();
    check("flight_rst_resp_val", {63'd0, mul_if.mulresp_val}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("flight_no_stale%0d", i), {63'd0, mul_if.mulresp_val}, 64'd0);
    end

    // Pipe still usable after the mid-flight reset
    do_single(13);
    do_single(14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
